// File: rtl/pq_acc_ctrl_if.sv
// Event, drain-stream and tick signals of the ping-pong accumulator controller.
interface pq_acc_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  tick;
    logic                  tick_ovf;
    logic                  ev_valid;
    logic                  ev_ready;
    logic [ADDR_WIDTH-1:0] ev_addr;
    logic [DATA_WIDTH-1:0] ev_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // valid/ready: a transfer happens on each rising clk edge where both are 1; the
    // source keeps valid and payload stable until then, ready never depends on a later valid.
    modport master (
        output tick, ev_valid, ev_addr, ev_data, out_ready,
        input  tick_ovf, ev_ready, out_valid, out_addr, out_data, out_last
    );

    modport slave (
        input  tick, ev_valid, ev_addr, ev_data, out_ready,
        output tick_ovf, ev_ready, out_valid, out_addr, out_data, out_last
    );
endinterface

// File: rtl/pq_acc_ctrl.sv
// Ping-pong accumulator controller: port 1 accumulates events into one bank while
// port 2 drains (read-and-clear) the other bank as a valid/ready stream.
module pq_acc_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pq_acc_ctrl_if.slave          bus,
    output logic                  ctrl_o,
    output logic                  clear_o,
    output logic                  rd_en1_o,
    output logic                  rd_en2_o,
    output logic                  wr_en1_o,
    output logic                  wr_en2_o,
    output logic [ADDR_WIDTH-1:0] rd_addr1_o,
    output logic [ADDR_WIDTH-1:0] rd_addr2_o,
    output logic [ADDR_WIDTH-1:0] wr_addr1_o,
    output logic [ADDR_WIDTH-1:0] wr_addr2_o,
    output logic [DATA_WIDTH-1:0] din1_o,
    output logic [DATA_WIDTH-1:0] din2_o,
    input  logic [DATA_WIDTH-1:0] dout1_i,
    input  logic [DATA_WIDTH-1:0] dout2_i,
    output logic [1:0]            state_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  ctrl_q, ctrl_d;
    logic                  tick_pend_q, tick_pend_d;
    logic                  sb_vld_q, sb_vld_d;
    logic [ADDR_WIDTH-1:0] sb_addr_q, sb_addr_d;
    logic [DATA_WIDTH-1:0] sb_data_q, sb_data_d;
    logic                  pw_vld_q, pw_vld_d;
    logic [ADDR_WIDTH-1:0] pw_addr_q, pw_addr_d;
    logic [DATA_WIDTH-1:0] pw_data_q, pw_data_d;
    logic                  drn_act_q, drn_act_d;
    logic [ADDR_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
    logic                  iss_done_q, iss_done_d;
    logic                  rdp_q, rdp_d;
    logic [ADDR_WIDTH-1:0] rdp_addr_q, rdp_addr_d;
    logic                  ov_q, ov_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;

    logic                  ev_rdy;
    logic                  ev_fire;
    logic                  drn_issue;
    logic                  out_fire;
    logic                  tick_ovf_w;
    logic [DATA_WIDTH-1:0] acc_old;
    logic [DATA_WIDTH:0]   acc_sum;
    logic [DATA_WIDTH-1:0] acc_sat;

    assign ev_rdy   = (state_q == ST_RUN) && !tick_pend_q;
    assign ev_fire  = bus.ev_valid && ev_rdy;
    assign out_fire = ov_q && bus.out_ready;
    // A read is only issued when the output register is guaranteed free on the capture cycle.
    assign drn_issue = drn_act_q && !iss_done_q && !rdp_q && (!ov_q || bus.out_ready);

    // Back-to-back events to one address see the write still in flight, not stale dout1.
    assign acc_old = (pw_vld_q && (pw_addr_q == sb_addr_q)) ? pw_data_q : dout1_i;
    assign acc_sum = {1'b0, acc_old} + {1'b0, sb_data_q};
    assign acc_sat = acc_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : acc_sum[DATA_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        sweep_d     = sweep_q;
        ctrl_d      = ctrl_q;
        tick_pend_d = tick_pend_q;
        sb_vld_d    = ev_fire;
        sb_addr_d   = ev_fire ? bus.ev_addr : '0;
        sb_data_d   = ev_fire ? bus.ev_data : '0;
        pw_vld_d    = sb_vld_q;
        pw_addr_d   = sb_vld_q ? sb_addr_q : '0;
        pw_data_d   = sb_vld_q ? acc_sat : '0;
        drn_act_d   = drn_act_q;
        iss_cnt_d   = iss_cnt_q;
        iss_done_d  = iss_done_q;
        rdp_d       = drn_issue;
        rdp_addr_d  = drn_issue ? iss_cnt_q : '0;
        ov_d        = ov_q;
        oaddr_d     = oaddr_q;
        odata_d     = odata_q;
        tick_ovf_w  = 1'b0;
        clear_o     = 1'b0;
        rd_en1_o    = ev_fire;
        rd_addr1_o  = ev_fire ? bus.ev_addr : '0;
        wr_en1_o    = 1'b0;
        wr_addr1_o  = '0;
        din1_o      = '0;
        rd_en2_o    = drn_issue;
        rd_addr2_o  = drn_issue ? iss_cnt_q : '0;
        wr_en2_o    = 1'b0;
        wr_addr2_o  = '0;
        din2_o      = '0;

        case (state_q)
            ST_INIT: begin
                if (armed_q) begin
                    clear_o    = 1'b1;
                    wr_en1_o   = 1'b1;
                    wr_addr1_o = sweep_q;
                    sweep_d    = sweep_q + 1'b1;
                    if (sweep_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        ctrl_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.tick) begin
                    if (tick_pend_q) tick_ovf_w = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
                if (tick_pend_q && !sb_vld_q && !drn_act_q) begin
                    state_d     = ST_SWAP;
                    ctrl_d      = !ctrl_q;
                    tick_pend_d = 1'b0;
                    drn_act_d   = 1'b1;
                    iss_cnt_d   = '0;
                    iss_done_d  = 1'b0;
                end
            end
            ST_SWAP: begin
                state_d = ST_RUN;
                if (bus.tick) tick_ovf_w = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        if (sb_vld_q) begin
            wr_en1_o   = 1'b1;
            wr_addr1_o = sb_addr_q;
            din1_o     = acc_sat;
        end

        if (drn_issue) begin
            iss_cnt_d = iss_cnt_q + 1'b1;
            if (iss_cnt_q == LAST_ADDR) iss_done_d = 1'b1;
        end

        if (out_fire) begin
            ov_d = 1'b0;
            if (oaddr_q == LAST_ADDR) drn_act_d = 1'b0;
        end

        // Capture the drained word and clear its slot in the same cycle.
        if (rdp_q) begin
            ov_d       = 1'b1;
            oaddr_d    = rdp_addr_q;
            odata_d    = dout2_i;
            wr_en2_o   = 1'b1;
            wr_addr2_o = rdp_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            armed_q     <= 1'b0;
            sweep_q     <= '0;
            ctrl_q      <= 1'b0;
            tick_pend_q <= 1'b0;
            sb_vld_q    <= 1'b0;
            sb_addr_q   <= '0;
            sb_data_q   <= '0;
            pw_vld_q    <= 1'b0;
            pw_addr_q   <= '0;
            pw_data_q   <= '0;
            drn_act_q   <= 1'b0;
            iss_cnt_q   <= '0;
            iss_done_q  <= 1'b0;
            rdp_q       <= 1'b0;
            rdp_addr_q  <= '0;
            ov_q        <= 1'b0;
            oaddr_q     <= '0;
            odata_q     <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            sweep_q     <= sweep_d;
            ctrl_q      <= ctrl_d;
            tick_pend_q <= tick_pend_d;
            sb_vld_q    <= sb_vld_d;
            sb_addr_q   <= sb_addr_d;
            sb_data_q   <= sb_data_d;
            pw_vld_q    <= pw_vld_d;
            pw_addr_q   <= pw_addr_d;
            pw_data_q   <= pw_data_d;
            drn_act_q   <= drn_act_d;
            iss_cnt_q   <= iss_cnt_d;
            iss_done_q  <= iss_done_d;
            rdp_q       <= rdp_d;
            rdp_addr_q  <= rdp_addr_d;
            ov_q        <= ov_d;
            oaddr_q     <= oaddr_d;
            odata_q     <= odata_d;
        end
    end

    assign ctrl_o        = ctrl_q;
    assign state_o       = state_q;
    assign bus.ev_ready  = ev_rdy;
    assign bus.tick_ovf  = tick_ovf_w;
    assign bus.out_valid = ov_q;
    assign bus.out_addr  = oaddr_q;
    assign bus.out_data  = odata_q;
    assign bus.out_last  = ov_q && (oaddr_q == LAST_ADDR);
endmodule
